axil_cfg_bridge: RTL

- AXI4-Lite slave that issues masked writes into a bank of NREG clock-gated config registers and reads back their contents.
- Decodes the AXI write address and drives the shared write word, one-hot per-register enables and the register-bank clock enable.
- Muxes the register outputs back onto the R channel.
- Sits between the interconnect and the DMA configuration bank. Each register treats the upper half of its write word as a bit-enable mask for the lower half, and loads its upper half unconditionally.

---
 rtl/axil_cfg_bridge.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/axil_cfg_bridge.sv
// AXI4-Lite slave driving a bank of clock-gated, self-masking config registers.
// Writes: AW/W latched independently, one EXEC cycle pulses cfg_en, then B; reads: 1-cycle capture.
module axil_cfg_bridge #(
  parameter int DW   = 32,
  parameter int NREG = 8,
  parameter int AW   = 5
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [AW-1:0]        s_awaddr,
  input  logic                 s_awvalid,
  output logic                 s_awready,
  input  logic [DW-1:0]        s_wdata,
  input  logic [DW/8-1:0]      s_wstrb,
  input  logic                 s_wvalid,
  output logic                 s_wready,
  output logic [1:0]           s_bresp,
  output logic                 s_bvalid,
  input  logic                 s_bready,
  input  logic [AW-1:0]        s_araddr,
  input  logic                 s_arvalid,
  output logic                 s_arready,
  output logic [DW-1:0]        s_rdata,
  output logic [1:0]           s_rresp,
  output logic                 s_rvalid,
  input  logic                 s_rready,
  output logic [DW-1:0]        cfg_wdata,
  output logic [NREG-1:0]      cfg_en,
  output logic                 cfg_clk_en,
  input  logic [NREG*DW-1:0]   cfg_rdata
);

  localparam int          IW     = AW - 2;
  localparam int          SW     = DW / 8;
  localparam int unsigned NREG_U = NREG;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {W_IDLE, W_GOT_AW, W_GOT_W, W_EXEC, W_RESP} wstate_t;
  typedef enum logic       {R_IDLE, R_DATA} rstate_t;

  wstate_t        wstate_q, wstate_d;
  logic [AW-1:0]  awaddr_q, awaddr_d;
  logic [DW-1:0]  wdata_q, wdata_d;
  logic [SW-1:0]  wstrb_q, wstrb_d;
  logic [1:0]     bresp_q, bresp_d;
  logic           clk_en_q;

  rstate_t        rstate_q, rstate_d;
  logic [DW-1:0]  rdata_q, rdata_d;
  logic [1:0]     rresp_q, rresp_d;

  logic [IW-1:0]  w_idx, r_idx;
  logic           w_idx_ok, w_strb_ok, w_legal, r_idx_ok;
  logic [DW-1:0]  rd_sel;

  assign w_idx     = awaddr_q[AW-1:2];
  assign w_idx_ok  = 32'(w_idx) < NREG_U;
  assign w_strb_ok = &wstrb_q;
  assign w_legal   = w_idx_ok && w_strb_ok;

  assign cfg_wdata  = wdata_q;
  assign cfg_clk_en = clk_en_q;
  assign s_bresp    = bresp_q;
  assign s_rdata    = rdata_q;
  assign s_rresp    = rresp_q;

  always_comb begin
    wstate_d  = wstate_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bresp_d   = bresp_q;
    s_awready = 1'b0;
    s_wready  = 1'b0;
    s_bvalid  = 1'b0;
    cfg_en    = '0;
    case (wstate_q)
      W_IDLE: begin
        s_awready = 1'b1;
        s_wready  = 1'b1;
        if (s_awvalid) awaddr_d = s_awaddr;
        if (s_wvalid) begin
          wdata_d = s_wdata;
          wstrb_d = s_wstrb;
        end
        if (s_awvalid && s_wvalid) wstate_d = W_EXEC;
        else if (s_awvalid)        wstate_d = W_GOT_AW;
        else if (s_wvalid)         wstate_d = W_GOT_W;
      end
      W_GOT_AW: begin
        s_wready = 1'b1;
        if (s_wvalid) begin
          wdata_d  = s_wdata;
          wstrb_d  = s_wstrb;
          wstate_d = W_EXEC;
        end
      end
      W_GOT_W: begin
        s_awready = 1'b1;
        if (s_awvalid) begin
          awaddr_d = s_awaddr;
          wstate_d = W_EXEC;
        end
      end
      W_EXEC: begin
        for (int unsigned k = 0; k < NREG_U; k++) begin
          cfg_en[k] = w_legal && (32'(w_idx) == k);
        end
        // An out-of-range index outranks a partial strobe.
        if (!w_idx_ok)       bresp_d = RESP_DECERR;
        else if (!w_strb_ok) bresp_d = RESP_SLVERR;
        else                 bresp_d = RESP_OKAY;
        wstate_d = W_RESP;
      end
      W_RESP: begin
        s_bvalid = 1'b1;
        if (s_bready) wstate_d = W_IDLE;
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wstate_q <= W_IDLE;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bresp_q  <= RESP_OKAY;
    end else begin
      wstate_q <= wstate_d;
      awaddr_q <= awaddr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      bresp_q  <= bresp_d;
    end
  end

  // Falling-edge flop keeps the gate enable glitch-free while clk is high.
  always_ff @(negedge clk or negedge resetn) begin
    if (!resetn) clk_en_q <= 1'b0;
    else         clk_en_q <= (wstate_q == W_EXEC) && w_legal;
  end

  assign r_idx    = s_araddr[AW-1:2];
  assign r_idx_ok = 32'(r_idx) < NREG_U;

  always_comb begin
    rd_sel = '0;
    for (int unsigned k = 0; k < NREG_U; k++) begin
      if (32'(r_idx) == k) rd_sel = cfg_rdata[k*DW +: DW];
    end
  end

  always_comb begin
    rstate_d  = rstate_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    s_arready = 1'b0;
    s_rvalid  = 1'b0;
    case (rstate_q)
      R_IDLE: begin
        s_arready = 1'b1;
        if (s_arvalid) begin
          rdata_d  = r_idx_ok ? rd_sel : '0;
          rresp_d  = r_idx_ok ? RESP_OKAY : RESP_DECERR;
          rstate_d = R_DATA;
        end
      end
      R_DATA: begin
        s_rvalid = 1'b1;
        if (s_rready) rstate_d = R_IDLE;
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rstate_q <= R_IDLE;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else begin
      rstate_q <= rstate_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
    end
  end

endmodule
